// File: rtl/mcpu_fb_pkg.sv
// Framebuffer geometry, fill FSM state encoding and pixel addressing helpers,
// shared by the rectangle fill engine and the video scan-out.
package mcpu_fb_pkg;

  localparam logic [11:0] FB_BASE          = 12'h800;
  localparam int          FB_W             = 128;
  localparam int          FB_H             = 120;
  localparam int          FB_WORDS_PER_ROW = FB_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } fb_state_e;

  function automatic logic [11:0] fb_word_addr(input logic [11:0] base, input int wpr,
                                               input logic [6:0] y, input logic [3:0] word);
    return base + 12'(32'(y) * 32'(wpr)) + {8'h00, word};
  endfunction

  function automatic logic [4:0] fb_nibble_lsb(input logic [6:0] x);
    return {x[2:0], 2'b00};
  endfunction

  // Expands a per-pixel mask to a per-bit mask over the 8 nibbles of a word.
  function automatic logic [31:0] fb_nibble_mask(input logic [7:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = {4{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/fb_fill_mask.sv
// Nibble mask for one framebuffer word: a bit is set for each pixel of the
// word whose x lies in [x0, x_end).
module fb_fill_mask (
  input  logic [3:0] word_i,
  input  logic [6:0] x0_i,
  input  logic [8:0] x_end_i,
  output logic [7:0] mask_o
);

  logic [8:0] px;

  always_comb begin
    mask_o = '0;
    px     = '0;
    for (int i = 0; i < 8; i++) begin
      px        = {2'b00, word_i, 3'(i)};
      mask_o[i] = (px >= {2'b00, x0_i}) && (px < x_end_i);
    end
  end

endmodule

// File: rtl/fb_fill.sv
// Rectangle fill engine: clips the request to the framebuffer, then writes each
// covered word once, doing read-modify-write only for partially covered words.
//   state | meaning
//   IDLE  | waiting for start
//   SETUP | clip bounds valid, pick first word or finish if empty
//   READ  | read of a partial word, held until granted
//   WAIT  | read data returns, merge into write data
//   WRITE | write of current word, held until granted
//   NEXT  | advance word/row or finish
//   DONE  | one-cycle done pulse
module fb_fill #(
  parameter logic [11:0] FB_BASE = mcpu_fb_pkg::FB_BASE,
  parameter int          FB_W    = mcpu_fb_pkg::FB_W,
  parameter int          FB_H    = mcpu_fb_pkg::FB_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  x0,
  input  logic [6:0]  y0,
  input  logic [7:0]  w,
  input  logic [7:0]  h,
  input  logic [3:0]  color,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  import mcpu_fb_pkg::*;

  localparam int WPR = FB_W / 8;

  fb_state_e   state_q;
  logic        busy_q, done_q, req_q, we_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [6:0]  x0_q, y0_q, row_q;
  logic [7:0]  w_q, h_q, mask_q;
  logic [3:0]  color_q, word_q;

  logic [8:0]  x_sum, y_sum, x_end, y_end;
  logic        empty_c, row_end_c, last_row_c, finish_c;
  logic [3:0]  nxt_word;
  logic [6:0]  nxt_row;
  logic [11:0] nxt_addr;
  logic [7:0]  nxt_mask;
  logic [31:0] nib, color_rep;

  // Sums are 9 bits wide so x0+w and y0+h never wrap before clipping.
  assign x_sum      = {2'b00, x0_q} + {1'b0, w_q};
  assign y_sum      = {2'b00, y0_q} + {1'b0, h_q};
  assign x_end      = (x_sum > 9'(FB_W)) ? 9'(FB_W) : x_sum;
  assign y_end      = (y_sum > 9'(FB_H)) ? 9'(FB_H) : y_sum;
  assign empty_c    = (x_end <= {2'b00, x0_q}) || (y_end <= {2'b00, y0_q});
  assign row_end_c  = ({2'b00, word_q, 3'b000} + 9'd8) >= x_end;
  assign last_row_c = ({2'b00, row_q} + 9'd1) >= y_end;

  always_comb begin
    nxt_word = x0_q[6:3];
    nxt_row  = y0_q;
    finish_c = empty_c;
    if (state_q == ST_NEXT) begin
      finish_c = 1'b0;
      if (!row_end_c) begin
        nxt_word = word_q + 4'd1;
        nxt_row  = row_q;
      end else if (!last_row_c) begin
        nxt_row = row_q + 7'd1;
      end else begin
        finish_c = 1'b1;
      end
    end
  end

  assign nxt_addr  = fb_word_addr(FB_BASE, WPR, nxt_row, nxt_word);
  assign nib       = fb_nibble_mask(mask_q);
  assign color_rep = {8{color_q}};

  fb_fill_mask u_mask (
    .word_i  (nxt_word),
    .x0_i    (x0_q),
    .x_end_i (x_end),
    .mask_o  (nxt_mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      row_q   <= '0;
      word_q  <= '0;
      mask_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          x0_q    <= x0;
          y0_q    <= y0;
          w_q     <= w;
          h_q     <= h;
          color_q <= color;
          busy_q  <= 1'b1;
          state_q <= ST_SETUP;
        end
        ST_SETUP, ST_NEXT: begin
          if (finish_c) begin
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            req_q  <= 1'b1;
            row_q  <= nxt_row;
            word_q <= nxt_word;
            addr_q <= nxt_addr;
            mask_q <= nxt_mask;
            if (nxt_mask == 8'hFF) begin
              wdata_q <= color_rep;
              we_q    <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              we_q    <= 1'b0;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: if (mem_gnt) state_q <= ST_WAIT;
        ST_WAIT: begin
          wdata_q <= (mem_rdata & ~nib) | (color_rep & nib);
          we_q    <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: if (mem_gnt) begin
          we_q    <= 1'b0;
          state_q <= ST_NEXT;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q & mem_gnt;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_fb_fill.sv
// Bench for fb_fill: behavioural framebuffer memory plus a pixel-level reference
// model; every fill result is compared against the model.
module tb_fb_fill;

  logic        clk = 1'b0;
  logic        reset, start, busy, done, mem_req, mem_gnt, mem_we;
  logic [6:0]  x0, y0;
  logic [7:0]  w, h;
  logic [3:0]  color;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_fill dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .busy(busy), .done(done), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [4096];
  logic [31:0] exp_mem [4096];
  logic        wr_flag [4096];
  logic        tb_init = 1'b0, tb_poke = 1'b0, gnt_rand = 1'b0;
  logic [31:0] init_seed = '0, poke_data = '0;
  logic [11:0] poke_addr = '0;
  int wr_cnt = 0, dup_cnt = 0, done_cnt = 0, stab_err = 0, we_err = 0, oob_cnt = 0;
  logic        g1 = 1'b1, g2 = 1'b1, b1 = 1'b0, b2 = 1'b0, r1 = 1'b0;
  logic [11:0] a1 = '0;
  logic [31:0] d1 = '0;

  function automatic logic [31:0] init_word(input int i, input logic [31:0] s);
    return (32'(i) * 32'h9E3779B1) ^ s;
  endfunction

  // Memory model, bus monitors and counters.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 4096; i++) begin
        mem[i]     <= init_word(i, init_seed);
        wr_flag[i] <= 1'b0;
      end
    end else if (tb_poke) begin
      mem[poke_addr] <= poke_data;
    end
    if (mem_req && mem_gnt && mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
      wr_cnt            <= wr_cnt + 1;
      if (wr_flag[mem_addr] === 1'b1) dup_cnt <= dup_cnt + 1;
      if (mem_addr < 12'h800 || mem_addr > 12'hF7F) oob_cnt <= oob_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
    if (b2 && b1 && busy && !g1 && !g2 &&
        (mem_addr !== a1 || mem_wdata !== d1 || mem_req !== r1))
      stab_err <= stab_err + 1;
    if (!mem_gnt && mem_we) we_err <= we_err + 1;
    if (done) done_cnt <= done_cnt + 1;
    g2 <= g1; g1 <= mem_gnt; b2 <= b1; b1 <= busy;
    a1 <= mem_addr; d1 <= mem_wdata; r1 <= mem_req;
  end

  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(negedge clk);
      mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_init(input logic [31:0] seed);
    @(negedge clk);
    init_seed = seed;
    tb_init   = 1'b1;
    @(negedge clk);
    tb_init = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = init_word(i, seed);
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_addr = a;
    poke_data = d;
    tb_poke   = 1'b1;
    @(negedge clk);
    tb_poke    = 1'b0;
    exp_mem[a] = d;
  endtask

  // Returns at the negedge of the cycle after the capturing edge.
  task automatic start_fill(input int xi, input int yi, input int wi, input int hi,
                            input logic [3:0] c);
    @(negedge clk);
    x0 = 7'(xi); y0 = 7'(yi); w = 8'(wi); h = 8'(hi); color = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pixel-by-pixel reference: clip, paint, and count distinct words touched.
  task automatic model_fill(input int xi, input int yi, input int wi, input int hi,
                            input logic [3:0] c, output int nwords);
    int xe, ye;
    xe = (xi + wi < 128) ? xi + wi : 128;
    ye = (yi + hi < 120) ? yi + hi : 120;
    nwords = 0;
    for (int y = yi; y < ye; y++) begin
      for (int x = xi; x < xe; x++) exp_mem[12'h800 + y*16 + x/8][4*(x%8) +: 4] = c;
      if (xe > xi) nwords += (xe - 1)/8 - xi/8 + 1;
    end
  endtask

  task automatic count_diffs(output int n, output int first);
    n = 0;
    first = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== exp_mem[i]) begin
        if (n == 0) first = i;
        n++;
      end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/req/we=%b want 0000", {busy, done, mem_req, mem_we});
    end
    checks++;
    if (mem_addr !== 12'h000 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_req, mem_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle: busy/done/req/we=%b want 0000", {busy, done, mem_req, mem_we});
    end
  endtask

  task automatic test_full_frame;
    int wb, db, dupb, ob, nw, n, f;
    bit ok;
    do_init(32'h1234_5678);
    gnt_rand = 1'b0;
    wb = wr_cnt; db = done_cnt; dupb = dup_cnt; ob = oob_cnt;
    model_fill(0, 0, 128, 120, 4'hA, nw);
    start_fill(0, 0, 128, 120, 4'hA);
    wait_done(8000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_done_timeout: no done within budget"); end
    checks++;
    if (wr_cnt - wb !== 1920) begin
      failures++; $display("FAIL full_writes: got %0d want 1920", wr_cnt - wb);
    end
    checks++;
    if (done_cnt - db !== 1) begin
      failures++; $display("FAIL full_done_count: got %0d want 1", done_cnt - db);
    end
    checks++;
    if (dup_cnt - dupb !== 0 || oob_cnt - ob !== 0) begin
      failures++; $display("FAIL full_dup_oob: dup=%0d oob=%0d want 0", dup_cnt - dupb, oob_cnt - ob);
    end
    checks++;
    if (mem[12'h800] !== 32'hAAAAAAAA || mem[12'hF7F] !== 32'hAAAAAAAA) begin
      failures++; $display("FAIL full_corners: 800=%h F7F=%h want AAAAAAAA", mem[12'h800], mem[12'hF7F]);
    end
    count_diffs(n, f);
    checks++;
    if (n !== 0) begin
      failures++; $display("FAIL full_mem: %0d diffs, first %h got %h want %h", n, f, mem[f], exp_mem[f]);
    end
  endtask

  task automatic test_partial_word(input bit rand_gnt);
    int wb, sb, eb, nw, n, f;
    bit ok;
    do_init(32'hCAFE_0001);
    poke(12'h800, 32'h76543210);
    gnt_rand = rand_gnt;
    wb = wr_cnt; sb = stab_err; eb = we_err;
    model_fill(2, 0, 3, 1, 4'hF, nw);
    start_fill(2, 0, 3, 1, 4'hF);
    wait_done(400, ok);
    gnt_rand = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL partial_done_timeout: gnt_rand=%0d", rand_gnt); end
    checks++;
    if (mem[12'h800] !== 32'h765FFF10) begin
      failures++; $display("FAIL partial_word: got %h want 765FFF10", mem[12'h800]);
    end
    checks++;
    if (wr_cnt - wb !== 1) begin
      failures++; $display("FAIL partial_writes: got %0d want 1", wr_cnt - wb);
    end
    count_diffs(n, f);
    checks++;
    if (n !== 0) begin
      failures++; $display("FAIL partial_mem: %0d diffs, first %h got %h want %h", n, f, mem[f], exp_mem[f]);
    end
    if (rand_gnt) begin
      checks++;
      if (stab_err - sb !== 0 || we_err - eb !== 0) begin
        failures++; $display("FAIL stall_stable: unstable=%0d we_no_gnt=%0d want 0", stab_err - sb, we_err - eb);
      end
    end
  endtask

  task automatic test_clip;
    int wb, ob, nw, n, f;
    bit ok;
    do_init(32'h0BAD_F00D);
    gnt_rand = 1'b0;
    wb = wr_cnt; ob = oob_cnt;
    model_fill(120, 118, 50, 50, 4'h3, nw);
    start_fill(120, 118, 50, 50, 4'h3);
    wait_done(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL clip_done_timeout: no done"); end
    checks++;
    if (wr_cnt - wb !== 2 || oob_cnt - ob !== 0) begin
      failures++; $display("FAIL clip_writes: writes=%0d oob=%0d want 2/0", wr_cnt - wb, oob_cnt - ob);
    end
    checks++;
    if (mem[12'hF6F] !== 32'h33333333 || mem[12'hF7F] !== 32'h33333333) begin
      failures++; $display("FAIL clip_words: F6F=%h F7F=%h want 33333333", mem[12'hF6F], mem[12'hF7F]);
    end
    count_diffs(n, f);
    checks++;
    if (n !== 0) begin
      failures++; $display("FAIL clip_mem: %0d diffs, first %h got %h want %h", n, f, mem[f], exp_mem[f]);
    end
  endtask

  task automatic test_empty;
    int cases [3][4] = '{'{5, 5, 0, 4}, '{9, 3, 20, 0}, '{10, 120, 8, 5}};
    int wb;
    bit ok;
    gnt_rand = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb = wr_cnt;
      start_fill(cases[k][0], cases[k][1], cases[k][2], cases[k][3], 4'h5);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++; $display("FAIL empty_setup_%0d: busy=%b done=%b want 1/0", k, busy, done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL empty_done_%0d: done=%b busy=%b want 1/0", k, done, busy);
      end
      wait_done(10, ok);
      repeat (2) @(negedge clk);
      checks++;
      if (wr_cnt - wb !== 0 || !ok) begin
        failures++; $display("FAIL empty_nowrite_%0d: writes=%0d done_seen=%0d want 0/1", k, wr_cnt - wb, ok);
      end
    end
  endtask

  task automatic test_back_to_back;
    int xi, yi, wi, hi, nw, wb, dupb, n, f;
    logic [3:0] c;
    bit seen;
    do_init(32'h5EED_0042);
    for (int it = 0; it < 12; it++) begin
      gnt_rand = it[0];
      xi = $urandom_range(0, 127); yi = $urandom_range(0, 127);
      wi = $urandom_range(0, 48);  hi = $urandom_range(0, 10);
      c  = 4'($urandom_range(0, 15));
      wb = wr_cnt; dupb = dup_cnt;
      model_fill(xi, yi, wi, hi, c, nw);
      start_fill(xi, yi, wi, hi, c);
      // start while busy must be ignored
      x0 = 7'd0; y0 = 7'd0; w = 8'd128; h = 8'd120; color = ~c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
        if (done === 1'b1) seen = 1'b1;
        else @(negedge clk);
      end
      // start during the done cycle must be ignored as well
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (!seen || busy !== 1'b0) begin
        failures++; $display("FAIL b2b_done_%0d: done_seen=%0d busy=%b want 1/0", it, seen, busy);
      end
      checks++;
      if (wr_cnt - wb !== nw || dup_cnt - dupb !== 0) begin
        failures++; $display("FAIL b2b_writes_%0d: writes=%0d dup=%0d want %0d/0", it, wr_cnt - wb, dup_cnt - dupb, nw);
      end
      count_diffs(n, f);
      checks++;
      if (n !== 0) begin
        failures++; $display("FAIL b2b_mem_%0d: %0d diffs, first %h got %h want %h", it, n, f, mem[f], exp_mem[f]);
      end
    end
    gnt_rand = 1'b0;
  endtask

  task automatic test_reset_mid;
    int wb, db, nw, n, f;
    bit ok, hit;
    do_init(32'h7777_AAAA);
    gnt_rand = 1'b0;
    wb = wr_cnt; db = done_cnt;
    start_fill(0, 0, 128, 120, 4'h9);
    hit = 1'b0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      if (wr_cnt - wb >= 5) hit = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!hit || wr_cnt - wb !== 5) begin
      failures++; $display("FAIL rstmid_fifth: reached=%0d writes=%0d want 1/5", hit, wr_cnt - wb);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_req, mem_we} !== 4'b0000 || mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_outputs: ctrl=%b addr=%h wdata=%h want 0", {busy, done, mem_req, mem_we}, mem_addr, mem_wdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (wr_cnt - wb !== 5 || done_cnt - db !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: writes=%0d done=%0d busy=%b want 5/0/0", wr_cnt - wb, done_cnt - db, busy);
    end
    for (int i = 0; i < 5; i++) exp_mem[12'h800 + i] = 32'h99999999;
    model_fill(3, 2, 20, 3, 4'hC, nw);
    db = done_cnt;
    start_fill(3, 2, 20, 3, 4'hC);
    wait_done(400, ok);
    checks++;
    if (!ok || done_cnt - db !== 1) begin
      failures++; $display("FAIL rstmid_refill_done: seen=%0d pulses=%0d want 1/1", ok, done_cnt - db);
    end
    count_diffs(n, f);
    checks++;
    if (n !== 0) begin
      failures++; $display("FAIL rstmid_mem: %0d diffs, first %h got %h want %h", n, f, mem[f], exp_mem[f]);
    end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_partial_word(1'b0);
    test_clip;
    test_empty;
    test_partial_word(1'b1);
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_fill.md
FB_FILL -- requirements
Module: fb_fill

Interface
REQ-001 Parameter FB_BASE, default 12'h800, word address of framebuffer row 0, pixel 0.
REQ-002 Parameter FB_W, default 128, framebuffer width in pixels; 8 pixels per 32-bit word.
REQ-003 Parameter FB_H, default 120, framebuffer height in rows.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request; captures x0, y0, w, h and color when idle.
REQ-007 x0, y0  input  7 each  top-left pixel of the rectangle.
REQ-008 w, h  input  8 each  rectangle width and height in pixels.
REQ-009 color  input  4  pixel value to fill.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse when the fill completes.
REQ-012 mem_req  output  1  bus request, held high while busy.
REQ-013 mem_gnt  input  1  bus grant; a memory cycle happens only while mem_req and mem_gnt are both high.
REQ-014 mem_addr  output  12  word address.
REQ-015 mem_we  output  1  write strobe.
REQ-016 mem_wdata  output  32  write data.
REQ-017 mem_rdata  input  32  read data, valid the cycle after a granted read with mem_addr held.

Function
REQ-018 Pixel (x, y) lives at word FB_BASE + y*(FB_W/8) + x[6:3], in nibble bits [4*x[2:0]+3 : 4*x[2:0]].
REQ-019 Clipping: x_end = min(x0+w, FB_W) and y_end = min(y0+h, FB_H), computed in 9 bits with no wrap.
REQ-020 Empty fills (w=0, h=0, x0>=FB_W or y0>=FB_H) go from IDLE to DONE with no memory access.
REQ-021 States are IDLE, SETUP, READ, WAIT, WRITE, NEXT and DONE.
REQ-022 SETUP computes the clip bounds, sets the current row to y0 and the current word to x0[6:3], and raises mem_req.
REQ-023 For each word, the nibble mask covers pixels p in [x0, x_end-1] within that word.
REQ-024 Full mask: go straight to WRITE with mem_wdata = color replicated 8 times (no read).
REQ-025 Partial mask: READ issues address with mem_we=0, WAIT captures mem_rdata, then WRITE merges (color in masked nibbles, read data elsewhere).
REQ-026 Every memory-issuing state stalls, holding all bus outputs stable, while mem_gnt=0.
REQ-027 NEXT advances the word and wraps to word x0[6:3] of the next row at the row end.
REQ-028 After the last word of row y_end-1, the machine enters DONE, which pulses done for one cycle and then returns to IDLE.
REQ-029 start while busy is ignored; start in the DONE cycle is also ignored.
REQ-030 mem_we is high only in WRITE with mem_gnt=1; mem_we=0 at all other times.
REQ-031 Each word is written exactly once; memory outside the clipped rectangle is never written.

Reset
REQ-032 Reset forces IDLE; busy, done, mem_req and mem_we go to 0, mem_addr and mem_wdata go to 0, and all captured registers clear.
REQ-033 Reset mid-fill abandons the fill with no further writes and no done pulse; a partially written rectangle remains.

Structure
REQ-034 Shared package mcpu_fb_pkg holds FB_BASE, FB_W, FB_H, the words-per-row constant, the state enum and the pixel address/nibble helper functions; the video scan-out uses the same package.
REQ-035 One sub-module, fb_fill_mask: combinational nibble-mask generator taking word index, x0 and x_end and producing an 8-bit mask.

Verification
REQ-036 x0=0, y0=0, w=128, h=120, color=4'hA, gnt always 1: 1920 writes of 32'hAAAAAAAA to 0x800..0xF7F, no reads, one done.
REQ-037 Prefill 32'h76543210 at 0x800; fill x0=2, y0=0, w=3, h=1, color=4'hF: one read and one write of 32'h765FFF10 at 0x800.
REQ-038 x0=120, y0=118, w=50, h=50, color=4'h3: only words 0x80F+y*16 for y=118,119 written with 32'h33333333, no address above 0xF7F.
REQ-039 w=0, color=4'h5: done one cycle after SETUP, zero memory cycles.
REQ-040 Random mem_gnt deassertion during the REQ-037 fill: same final memory, and bus outputs stable while gnt=0.
REQ-041 Reset asserted mid-fill after the 5th write: outputs go to 0 immediately, no further writes, no done pulse; a following start fills normally.
